// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA timing controller.
package vga_pkg;

  localparam int RGB_W = 12;
  localparam int CNT_W = 12;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  typedef logic [RGB_W-1:0] rgb_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Timing qualifiers travelling together through the output delay line.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
  } vid_ctl_t;

  function automatic int span_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Raw timing decode handed from the raster counters to the output pipeline.
interface vga_timing_ctrl_if;
  import vga_pkg::*;

  vid_ctl_t raw;

  modport master (output raw);
  modport slave  (input  raw);
endinterface

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical raster counters plus active, sync and frame-origin decode.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic              clk_v,
  input  logic              resetn_v,
  input  logic              en_i,
  vga_timing_ctrl_if.master tim
);

  localparam int   H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int   V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam cnt_t H_LAST  = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST  = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_ACT   = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT   = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_BEG  = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END  = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t VS_BEG  = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END  = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

  cnt_t h_cnt_q, h_cnt_d;
  cnt_t v_cnt_q, v_cnt_d;

  // Disabled means parked at the origin, so every enable starts a fresh frame.
  always_comb begin
    h_cnt_d = '0;
    v_cnt_d = '0;
    if (en_i) begin
      if (h_cnt_q == H_LAST) begin
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + cnt_t'(1);
      end else begin
        h_cnt_d = h_cnt_q + cnt_t'(1);
        v_cnt_d = v_cnt_q;
      end
    end
  end

  always_ff @(posedge clk_v or negedge resetn_v) begin
    if (!resetn_v) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Gating with en_i lets a disable suppress the very next request.
  always_comb begin
    tim.raw = '0;
    if (en_i) begin
      tim.raw.de = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
      tim.raw.hs = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
      tim.raw.vs = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
      tim.raw.fs = (h_cnt_q == '0) && (v_cnt_q == '0);
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing controller: raster generator plus a 3-stage output pipeline that
// issues pixel requests and aligns returned pixels with sync/enable outputs.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic clk_v,
  input  logic resetn_v,
  input  logic en_i,
  output logic data_req_o,
  input  rgb_t data_i,
  output logic hsync_o,
  output logic vsync_o,
  output rgb_t rgb_o,
  output logic de_o,
  output logic frame_start_o
);

  vga_timing_ctrl_if tim_if ();

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_gen (
    .clk_v    (clk_v),
    .resetn_v (resetn_v),
    .en_i     (en_i),
    .tim      (tim_if)
  );

  vid_ctl_t st1_q, st1_d;
  vid_ctl_t st2_q, st2_d;
  vid_ctl_t st3_q, st3_d;
  rgb_t     rgb_q, rgb_d;

  // Stage 1 is the request; pixel data arrives while stage 2 holds its qualifiers.
  always_comb begin
    st1_d = tim_if.raw;
    st2_d = st1_q;
    st3_d = st2_q;
    rgb_d = st2_q.de ? data_i : '0;
    if (!en_i) begin
      st1_d = '0;
      st2_d = '0;
      st3_d = '0;
      rgb_d = '0;
    end
  end

  always_ff @(posedge clk_v or negedge resetn_v) begin
    if (!resetn_v) begin
      st1_q <= '0;
      st2_q <= '0;
      st3_q <= '0;
      rgb_q <= '0;
    end else begin
      st1_q <= st1_d;
      st2_q <= st2_d;
      st3_q <= st3_d;
      rgb_q <= rgb_d;
    end
  end

  assign data_req_o    = st1_q.de;
  assign de_o          = st3_q.de;
  assign frame_start_o = st3_q.fs;
  assign rgb_o         = rgb_q;
  assign hsync_o       = st3_q.hs ? SYNC_POL : ~SYNC_POL;
  assign vsync_o       = st3_q.vs ? SYNC_POL : ~SYNC_POL;

endmodule
